// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register.
// Contents:
//   state_t     - occupancy state of a stage (empty / main only / main+skid)
//   WB_W/MEM_W  - widths of the write-back and memory control groups
//   CTRL_DEF_W  - default control field width (WB + MEM bits)
//   REG_IDX_W   - architectural register index width
package pipe_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   localparam int WB_W       = 2;
   localparam int MEM_W      = 3;
   localparam int CTRL_DEF_W = WB_W + MEM_W;
   localparam int REG_IDX_W  = 5;

endpackage

// File: rtl/pipe_slot.sv
// One storage entry of a pipeline stage: {valid, ctrl, data, dest}.
// Ports:
//   clk, r_n          - clock, asynchronous active-low reset
//   load              - capture load_ctrl/load_data/load_dest and set valid
//   clear             - drop the entry: zeroes valid/ctrl/dest, data is kept
//   load_ctrl/_data/_dest - values captured on load
//   valid, ctrl, data, dest - registered entry contents
// clear has priority over load.
module pipe_slot
   import pipe_pkg::*;
#(
   parameter int CTRL_W    = CTRL_DEF_W,
   parameter int DATA_BITS = 64,
   parameter int DEST_W    = REG_IDX_W
) (
   input  logic                 clk,
   input  logic                 r_n,
   input  logic                 load,
   input  logic                 clear,
   input  logic [CTRL_W-1:0]    load_ctrl,
   input  logic [DATA_BITS-1:0] load_data,
   input  logic [DEST_W-1:0]    load_dest,
   output logic                 valid,
   output logic [CTRL_W-1:0]    ctrl,
   output logic [DATA_BITS-1:0] data,
   output logic [DEST_W-1:0]    dest
);

   logic                 valid_r;
   logic [CTRL_W-1:0]    ctrl_r;
   logic [DATA_BITS-1:0] data_r;
   logic [DEST_W-1:0]    dest_r;

   // Entry storage: clear drops the beat and zeroes its control/dest fields.
   always_ff @(posedge clk or negedge r_n) begin
      if (!r_n) begin
         valid_r <= 1'b0;
         ctrl_r  <= {CTRL_W{1'b0}};
         data_r  <= {DATA_BITS{1'b0}};
         dest_r  <= {DEST_W{1'b0}};
      end else if (clear) begin
         valid_r <= 1'b0;
         ctrl_r  <= {CTRL_W{1'b0}};
         dest_r  <= {DEST_W{1'b0}};
      end else if (load) begin
         valid_r <= 1'b1;
         ctrl_r  <= load_ctrl;
         data_r  <= load_data;
         dest_r  <= load_dest;
      end
   end

   assign valid = valid_r;
   assign ctrl  = ctrl_r;
   assign data  = data_r;
   assign dest  = dest_r;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready flow control, optional skid entry
// and synchronous flush.
// Ports:
//   clk, r_n                      - clock, asynchronous active-low reset
//   in_valid/in_ready             - upstream handshake
//   in_ctrl/in_data/in_dest       - incoming beat (data word 0 in LSBs)
//   flush                         - squash held and incoming beats
//   out_valid/out_ready           - downstream handshake
//   out_ctrl/out_data/out_dest    - registered beat, driven from the main entry
//   full                          - every entry occupied
// SKID=1: two entries, in_ready comes straight from the skid valid flop.
// SKID=0: one entry, in_ready = !out_valid | out_ready (combinational).
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int CTRL_W   = CTRL_DEF_W,
   parameter int DATA_W   = 32,
   parameter int NUM_DATA = 2,
   parameter int DEST_W   = REG_IDX_W,
   parameter int SKID     = 1
) (
   input  logic                       clk,
   input  logic                       r_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [CTRL_W-1:0]          in_ctrl,
   input  logic [NUM_DATA*DATA_W-1:0] in_data,
   input  logic [DEST_W-1:0]          in_dest,
   input  logic                       flush,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [CTRL_W-1:0]          out_ctrl,
   output logic [NUM_DATA*DATA_W-1:0] out_data,
   output logic [DEST_W-1:0]          out_dest,
   output logic                       full
);

   localparam int DB = NUM_DATA * DATA_W;

   logic              in_ready_s;
   logic              accept_s;
   logic              pop_s;
   logic              main_load_s;
   logic              main_clear_s;
   logic [CTRL_W-1:0] main_ld_ctrl_s;
   logic [DB-1:0]     main_ld_data_s;
   logic [DEST_W-1:0] main_ld_dest_s;
   logic              main_valid_s;

   assign accept_s = in_valid & in_ready_s;
   assign pop_s    = main_valid_s & out_ready;

   pipe_slot #(.CTRL_W(CTRL_W), .DATA_BITS(DB), .DEST_W(DEST_W)) u_main (
      .clk       (clk),
      .r_n       (r_n),
      .load      (main_load_s),
      .clear     (main_clear_s),
      .load_ctrl (main_ld_ctrl_s),
      .load_data (main_ld_data_s),
      .load_dest (main_ld_dest_s),
      .valid     (main_valid_s),
      .ctrl      (out_ctrl),
      .data      (out_data),
      .dest      (out_dest)
   );

   generate
      if (SKID != 0) begin : g_skid
         logic              skid_load_s;
         logic              skid_clear_s;
         logic              from_skid_s;
         logic              skid_valid_s;
         logic [CTRL_W-1:0] skid_ctrl_s;
         logic [DB-1:0]     skid_data_s;
         logic [DEST_W-1:0] skid_dest_s;
         state_t            state_s;

         pipe_slot #(.CTRL_W(CTRL_W), .DATA_BITS(DB), .DEST_W(DEST_W)) u_skid (
            .clk       (clk),
            .r_n       (r_n),
            .load      (skid_load_s),
            .clear     (skid_clear_s),
            .load_ctrl (in_ctrl),
            .load_data (in_data),
            .load_dest (in_dest),
            .valid     (skid_valid_s),
            .ctrl      (skid_ctrl_s),
            .data      (skid_data_s),
            .dest      (skid_dest_s)
         );

         // The occupancy state is fully described by the two valid flops.
         assign state_s = skid_valid_s ? ST_TWO : (main_valid_s ? ST_ONE : ST_EMPTY);

         // Ready depends only on a flop, so there is no out_ready->in_ready path.
         assign in_ready_s = ~skid_valid_s;

         assign main_ld_ctrl_s = from_skid_s ? skid_ctrl_s : in_ctrl;
         assign main_ld_data_s = from_skid_s ? skid_data_s : in_data;
         assign main_ld_dest_s = from_skid_s ? skid_dest_s : in_dest;

         // Next-entry control for the two-entry stage; flush overrides everything.
         always_comb begin
            main_load_s  = 1'b0;
            main_clear_s = 1'b0;
            skid_load_s  = 1'b0;
            skid_clear_s = 1'b0;
            from_skid_s  = 1'b0;
            if (flush) begin
               main_clear_s = 1'b1;
               skid_clear_s = 1'b1;
            end else begin
               case (state_s)
                  ST_EMPTY: begin
                     if (accept_s) main_load_s = 1'b1;
                     else          main_load_s = 1'b0;
                  end
                  ST_ONE: begin
                     if (accept_s && pop_s) main_load_s  = 1'b1;
                     else if (accept_s)     skid_load_s  = 1'b1;
                     else if (pop_s)        main_clear_s = 1'b1;
                     else                   main_load_s  = 1'b0;
                  end
                  ST_TWO: begin
                     // Drain the skid entry into main; upstream is stalled here.
                     if (pop_s) begin
                        main_load_s  = 1'b1;
                        from_skid_s  = 1'b1;
                        skid_clear_s = 1'b1;
                     end else begin
                        main_load_s  = 1'b0;
                     end
                  end
                  default: begin
                     main_clear_s = 1'b1;
                     skid_clear_s = 1'b1;
                  end
               endcase
            end
         end

         assign full = skid_valid_s;
      end else begin : g_noskid
         assign in_ready_s     = ~main_valid_s | out_ready;
         assign main_ld_ctrl_s = in_ctrl;
         assign main_ld_data_s = in_data;
         assign main_ld_dest_s = in_dest;

         // Next-entry control for the single-entry stage; flush overrides.
         always_comb begin
            main_load_s  = 1'b0;
            main_clear_s = 1'b0;
            if (flush)         main_clear_s = 1'b1;
            else if (accept_s) main_load_s  = 1'b1;
            else if (pop_s)    main_clear_s = 1'b1;
            else               main_load_s  = 1'b0;
         end

         assign full = main_valid_s;
      end
   endgenerate

   assign in_ready  = in_ready_s;
   assign out_valid = main_valid_s;

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

   typedef struct packed {
      logic [4:0]  c;
      logic [63:0] d;
      logic [4:0]  t;
   } beat_t;

   logic        clk = 1'b0;
   logic        r_n;
   logic        in_valid;
   logic [4:0]  in_ctrl;
   logic [63:0] in_data;
   logic [4:0]  in_dest;
   logic        flush;
   logic        out_ready;

   logic        irdy1, ov1, full1;
   logic [4:0]  oc1, odst1;
   logic [63:0] od1;
   logic        irdy0, ov0, full0;
   logic [4:0]  oc0, odst0;
   logic [63:0] od0;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   pipe_stage_reg #(.CTRL_W(5), .DATA_W(32), .NUM_DATA(2), .DEST_W(5), .SKID(1)) dut1 (
      .clk(clk), .r_n(r_n), .in_valid(in_valid), .in_ready(irdy1), .in_ctrl(in_ctrl),
      .in_data(in_data), .in_dest(in_dest), .flush(flush), .out_valid(ov1),
      .out_ready(out_ready), .out_ctrl(oc1), .out_data(od1), .out_dest(odst1), .full(full1));

   pipe_stage_reg #(.CTRL_W(5), .DATA_W(32), .NUM_DATA(2), .DEST_W(5), .SKID(0)) dut0 (
      .clk(clk), .r_n(r_n), .in_valid(in_valid), .in_ready(irdy0), .in_ctrl(in_ctrl),
      .in_data(in_data), .in_dest(in_dest), .flush(flush), .out_valid(ov0),
      .out_ready(out_ready), .out_ctrl(oc0), .out_data(od0), .out_dest(odst0), .full(full0));

   // Beat n carries recognisable, non-zero ctrl/dest for small n.
   function automatic logic [4:0] bc(input logic [31:0] n);
      return n[4:0] ^ 5'h10;
   endfunction
   function automatic logic [4:0] bt(input logic [31:0] n);
      return n[4:0] ^ 5'h13;
   endfunction
   function automatic logic [63:0] bd(input logic [31:0] n);
      return {~n, n};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] n);
      in_valid = v;
      in_ctrl  = bc(n);
      in_data  = bd(n);
      in_dest  = bt(n);
   endtask

   task automatic do_reset();
      r_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
      drive(1'b0, 32'd0);
      tick(); tick();
      r_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      out_ready = 1'b0;
      drive(1'b1, 32'd1); tick();
      drive(1'b1, 32'd2); tick();
      drive(1'b1, 32'd3);
      #2 r_n = 1'b0;
      #1;
      n_cmp++; if (ov1 !== 1'b0)      begin n_bad++; $display("FAIL rst_ov1: got %b want 0", ov1); end
      n_cmp++; if (ov0 !== 1'b0)      begin n_bad++; $display("FAIL rst_ov0: got %b want 0", ov0); end
      n_cmp++; if (oc1 !== 5'h00)     begin n_bad++; $display("FAIL rst_oc1: got %h want 00", oc1); end
      n_cmp++; if (odst1 !== 5'h00)   begin n_bad++; $display("FAIL rst_dest1: got %h want 00", odst1); end
      n_cmp++; if (od1 !== 64'h0)     begin n_bad++; $display("FAIL rst_od1: got %h want 0", od1); end
      n_cmp++; if (irdy1 !== 1'b1)    begin n_bad++; $display("FAIL rst_irdy1: got %b want 1", irdy1); end
      n_cmp++; if (irdy0 !== 1'b1)    begin n_bad++; $display("FAIL rst_irdy0: got %b want 1", irdy0); end
      n_cmp++; if (full1 !== 1'b0)    begin n_bad++; $display("FAIL rst_full1: got %b want 0", full1); end
      n_cmp++; if (full0 !== 1'b0)    begin n_bad++; $display("FAIL rst_full0: got %b want 0", full0); end
      tick();
      n_cmp++; if (ov1 !== 1'b0)      begin n_bad++; $display("FAIL rst_hold_ov1: got %b want 0", ov1); end
      r_n = 1'b1;
      tick();
      n_cmp++; if (ov1 !== 1'b1 || od1 !== bd(3)) begin n_bad++; $display("FAIL rst_first_accept: got %b/%h want 1/%h", ov1, od1, bd(3)); end
      n_cmp++; if (ov0 !== 1'b1 || od0 !== bd(3)) begin n_bad++; $display("FAIL rst_first_accept0: got %b/%h want 1/%h", ov0, od0, bd(3)); end
   endtask

   task automatic test_streaming();
      do_reset();
      out_ready = 1'b1;
      drive(1'b1, 32'd1);
      for (int i = 1; i <= 8; i++) begin
         tick();
         n_cmp++; if (ov1 !== 1'b1 || od1 !== bd(i) || oc1 !== bc(i)) begin n_bad++; $display("FAIL stream1[%0d]: got %b/%h want 1/%h", i, ov1, od1, bd(i)); end
         n_cmp++; if (ov0 !== 1'b1 || od0 !== bd(i) || odst0 !== bt(i)) begin n_bad++; $display("FAIL stream0[%0d]: got %b/%h want 1/%h", i, ov0, od0, bd(i)); end
         if (i < 8) drive(1'b1, i + 1);
         else       drive(1'b0, 32'd0);
      end
      tick();
      n_cmp++; if (ov1 !== 1'b0 || oc1 !== 5'h00 || odst1 !== 5'h00) begin n_bad++; $display("FAIL stream_drain1: got %b/%h/%h want 0/00/00", ov1, oc1, odst1); end
      n_cmp++; if (ov0 !== 1'b0 || oc0 !== 5'h00 || odst0 !== 5'h00) begin n_bad++; $display("FAIL stream_drain0: got %b/%h/%h want 0/00/00", ov0, oc0, odst0); end
   endtask

   task automatic test_backpressure();
      do_reset();
      out_ready = 1'b0;
      drive(1'b1, 32'hA); tick();
      drive(1'b1, 32'hB); tick();
      n_cmp++; if (irdy1 !== 1'b0 || full1 !== 1'b1) begin n_bad++; $display("FAIL bp_two: got rdy %b full %b want 0/1", irdy1, full1); end
      drive(1'b1, 32'hC); tick();
      n_cmp++; if (od1 !== bd(32'hA) || irdy1 !== 1'b0) begin n_bad++; $display("FAIL bp_hold: got %h/%b want %h/0", od1, irdy1, bd(32'hA)); end
      out_ready = 1'b1; tick();
      n_cmp++; if (od1 !== bd(32'hB) || irdy1 !== 1'b1) begin n_bad++; $display("FAIL bp_b: got %h/%b want %h/1", od1, irdy1, bd(32'hB)); end
      tick();
      n_cmp++; if (ov1 !== 1'b1 || od1 !== bd(32'hC)) begin n_bad++; $display("FAIL bp_c: got %b/%h want 1/%h", ov1, od1, bd(32'hC)); end
      drive(1'b0, 32'd0); tick();
      n_cmp++; if (ov1 !== 1'b0) begin n_bad++; $display("FAIL bp_empty: got %b want 0", ov1); end
   endtask

   task automatic test_flush();
      do_reset();
      out_ready = 1'b0;
      drive(1'b1, 32'h1); tick();
      drive(1'b1, 32'h2); tick();
      drive(1'b1, 32'h7); flush = 1'b1; out_ready = 1'b1;
      tick();
      flush = 1'b0;
      n_cmp++; if (ov1 !== 1'b0 || oc1 !== 5'h00 || odst1 !== 5'h00) begin n_bad++; $display("FAIL flush_out1: got %b/%h/%h want 0/00/00", ov1, oc1, odst1); end
      n_cmp++; if (irdy1 !== 1'b1 || full1 !== 1'b0) begin n_bad++; $display("FAIL flush_rdy1: got %b/%b want 1/0", irdy1, full1); end
      n_cmp++; if (ov0 !== 1'b0 || oc0 !== 5'h00) begin n_bad++; $display("FAIL flush_out0: got %b/%h want 0/00", ov0, oc0); end
      drive(1'b0, 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++; if (ov1 !== 1'b0) begin n_bad++; $display("FAIL flush_ghost[%0d]: got %b want 0", i, ov1); end
      end
   endtask

   task automatic test_skid0_toggle();
      int cnt, nin, nout;
      logic exp_rdy;
      do_reset();
      cnt = 0; nin = 1; nout = 1;
      for (int cyc = 0; cyc < 16; cyc++) begin
         out_ready = cyc[0];
         drive(1'b1, nin);
         @(negedge clk);
         exp_rdy = (cnt == 0) || out_ready;
         n_cmp++; if (irdy0 !== exp_rdy) begin n_bad++; $display("FAIL tog_rdy[%0d]: got %b want %b", cyc, irdy0, exp_rdy); end
         n_cmp++; if (ov0 !== (cnt == 1)) begin n_bad++; $display("FAIL tog_ov[%0d]: got %b want %b", cyc, ov0, cnt == 1); end
         if (cnt == 1) begin
            n_cmp++; if (od0 !== bd(nout)) begin n_bad++; $display("FAIL tog_data[%0d]: got %h want %h", cyc, od0, bd(nout)); end
         end
         if (cnt == 1 && out_ready) begin cnt--; nout++; end
         if (exp_rdy) begin cnt++; nin++; end
         tick();
      end
   endtask

   task automatic test_accept_pop();
      do_reset();
      out_ready = 1'b0;
      drive(1'b1, 32'h3); tick();
      in_valid = 1'b1; in_ctrl = 5'h1F; in_dest = 5'd5; in_data = 64'h5555_0000_1234_5678;
      out_ready = 1'b1;
      tick();
      n_cmp++; if (ov1 !== 1'b1 || oc1 !== 5'h1F || odst1 !== 5'd5) begin n_bad++; $display("FAIL ap_out1: got %b/%h/%h want 1/1f/05", ov1, oc1, odst1); end
      n_cmp++; if (irdy1 !== 1'b1 || full1 !== 1'b0) begin n_bad++; $display("FAIL ap_state1: got %b/%b want 1/0", irdy1, full1); end
      n_cmp++; if (ov0 !== 1'b1 || oc0 !== 5'h1F || odst0 !== 5'd5) begin n_bad++; $display("FAIL ap_out0: got %b/%h/%h want 1/1f/05", ov0, oc0, odst0); end
   endtask

   task automatic test_random();
      beat_t q1[$];
      beat_t q0[$];
      beat_t nb;
      logic  r1, r0, v1, v0;
      do_reset();
      for (int cyc = 0; cyc < 500; cyc++) begin
         nb.c = 5'($urandom); nb.t = 5'($urandom); nb.d = {$urandom, $urandom};
         in_valid = ($urandom_range(3) != 0);
         in_ctrl = nb.c; in_dest = nb.t; in_data = nb.d;
         out_ready = 1'($urandom_range(1));
         flush = ($urandom_range(15) == 0);
         @(negedge clk);
         v1 = (q1.size() > 0);
         v0 = (q0.size() > 0);
         r1 = (q1.size() < 2);
         r0 = (q0.size() == 0) || out_ready;
         n_cmp++; if (ov1 !== v1 || irdy1 !== r1 || full1 !== (q1.size() == 2)) begin n_bad++; $display("FAIL rnd_hs1[%0d]: got v%b r%b f%b want v%b r%b n%0d", cyc, ov1, irdy1, full1, v1, r1, q1.size()); end
         n_cmp++; if (ov0 !== v0 || irdy0 !== r0 || full0 !== v0) begin n_bad++; $display("FAIL rnd_hs0[%0d]: got v%b r%b f%b want v%b r%b", cyc, ov0, irdy0, full0, v0, r0); end
         if (v1) begin
            n_cmp++; if ({oc1, od1, odst1} !== {q1[0].c, q1[0].d, q1[0].t}) begin n_bad++; $display("FAIL rnd_beat1[%0d]: got %h/%h/%h want %h/%h/%h", cyc, oc1, od1, odst1, q1[0].c, q1[0].d, q1[0].t); end
         end else begin
            n_cmp++; if (oc1 !== 5'h00 || odst1 !== 5'h00) begin n_bad++; $display("FAIL rnd_bubble1[%0d]: got %h/%h want 00/00", cyc, oc1, odst1); end
         end
         if (v0) begin
            n_cmp++; if ({oc0, od0, odst0} !== {q0[0].c, q0[0].d, q0[0].t}) begin n_bad++; $display("FAIL rnd_beat0[%0d]: got %h/%h/%h want %h/%h/%h", cyc, oc0, od0, odst0, q0[0].c, q0[0].d, q0[0].t); end
         end else begin
            n_cmp++; if (oc0 !== 5'h00 || odst0 !== 5'h00) begin n_bad++; $display("FAIL rnd_bubble0[%0d]: got %h/%h want 00/00", cyc, oc0, odst0); end
         end
         if (flush) begin
            q1.delete(); q0.delete();
         end else begin
            if (v1 && out_ready) void'(q1.pop_front());
            if (in_valid && r1) q1.push_back(nb);
            if (v0 && out_ready) void'(q0.pop_front());
            if (in_valid && r0) q0.push_back(nb);
         end
         tick();
      end
      flush = 1'b0;
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_backpressure();
      test_flush();
      test_skid0_toggle();
      test_accept_pop();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register with valid/ready flow control, an optional skid entry, and a synchronous flush that inserts a bubble. It sits between any two datapath stages (ID/EX, EX/MEM, MEM/WB) and carries control bits, data words and a destination register index, one beat per cycle. It replaces fixed-width per-stage registers: stalls become backpressure and squashes become flushes.

## Interface
Parameters:
- CTRL_W, 5, control field width (WB+MEM bits); zeroed on bubble
- DATA_W, 32, width of one data word
- NUM_DATA, 2, number of data words carried (ALU result, store data, ...)
- DEST_W, 5, destination register index width; zeroed on bubble
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready

Ports:
- clk  in  1  clock; all state changes on rising edge
- r_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  upstream beat present
- in_ready  out  1  stage can accept a beat this cycle
- in_ctrl  in  CTRL_W  control field
- in_data  in  NUM_DATA*DATA_W  data words, word 0 in LSBs
- in_dest  in  DEST_W  destination register index
- flush  in  1  synchronous squash of all held and incoming beats
- out_valid  out  1  beat present on outputs
- out_ready  in  1  downstream accepts beat
- out_ctrl  out  CTRL_W  registered control
- out_data  out  NUM_DATA*DATA_W  registered data
- out_dest  out  DEST_W  registered destination
- full  out  1  every entry occupied (SKID=1: skid entry valid; SKID=0: main valid)

## Operation
- accept = in_valid & in_ready; pop = out_valid & out_ready.
- Outputs always driven from the main entry; skid entry is never visible.
- Bubble rule: whenever out_valid=0, out_ctrl=0 and out_dest=0; out_data holds its last value (don't-care).
- SKID=1, states EMPTY / ONE / TWO (main only, main+skid); in_ready = (state != TWO), from flops.
  - EMPTY: accept -> ONE (main<=in).
  - ONE: accept&pop -> ONE (main<=in); accept&!pop -> TWO (skid<=in); !accept&pop -> EMPTY; else hold.
  - TWO: no accept possible; pop -> ONE (main<=skid); else hold.
- SKID=0, states EMPTY / FULL; in_ready = !out_valid | out_ready (combinational path from out_ready).
  - accept loads main; pop without accept -> EMPTY.
- flush: highest priority; next state EMPTY, both valids cleared, ctrl/dest of both entries zeroed, incoming beat dropped even if accept is high. A pop in the flush cycle still completes downstream.
- Ordering: strict FIFO; no beat duplicated or lost except by flush.
- Reset (r_n=0, immediate): state EMPTY, out_valid=0, out_ctrl=0, out_dest=0, out_data=0, skid contents 0, full=0; in_ready=1 for both SKID values.

## Timing
- Latency: beat accepted at edge N appears on outputs after edge N (visible cycle N+1).
- Throughput: 1 beat/cycle sustained while out_ready=1.
- SKID=1: in_ready falls the cycle after the skid entry fills; it rises the cycle after the pop that drains skid into main. No combinational in->out or out_ready->in_ready path.
- flush at edge N: out_valid=0 and in_ready=1 from cycle N+1.
- r_n asserted mid-transfer: beats discarded; release is synchronised externally, first accept allowed on the first edge after release.

## Structure
- Package pipe_pkg: state enum (ST_EMPTY, ST_ONE, ST_TWO), WB_W=2, MEM_W=3, default CTRL_W = WB_W+MEM_W, REG_IDX_W=5.
- One sub-module pipe_slot: single entry {valid, ctrl, data, dest} with load, clear (zeroes valid/ctrl/dest) and async reset; instantiated as main, and as skid when SKID=1.

## Test plan
- Reset: r_n low mid-stream with in_valid=1 -> out_valid=0, out_ctrl=0, out_dest=0, in_ready=1 immediately.
- Streaming: 8 beats data 0x1..0x8, out_ready=1 -> outputs 0x1..0x8 on consecutive cycles, one cycle after input.
- Backpressure (SKID=1): out_ready=0 while feeding 0xA,0xB,0xC -> 0xA in main, 0xB in skid, in_ready=0, 0xC held upstream; out_ready=1 -> 0xA,0xB,0xC delivered in order, none lost.
- Flush in TWO with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, out_dest=0, in_ready=1; flushed and incoming beats never appear.
- SKID=0: out_ready toggling 1/0 each cycle -> in_ready follows out_ready combinationally when full; order preserved.
- Simultaneous accept+pop in ONE with dest=5, ctrl=0x1F -> state stays ONE, new beat on outputs, no cycle gap.
